// File: rtl/seg_pkg.sv
// Shared seven-segment definitions for the scan decoder and any display driver.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
// Contents: digit count, segment width, hex glyph table (bit6=A .. bit0=G),
//           scan-sample type and the enable-bus classification helper.
package seg_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int SEG_W      = 7;
  localparam int CNT_W      = 8;

  localparam logic [SEG_W-1:0] SEG_BLANK = '0;

  // Index k of this table is the hex value the glyph represents.
  localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef enum logic [1:0] {
    SLOT_IDLE,    // no digit selected
    SLOT_SINGLE,  // exactly one digit selected
    SLOT_MULTI    // two or more digits selected at once
  } slot_kind_e;

  // One registered scan sample: active-low digit selects plus segment bus.
  typedef struct packed {
    logic [NUM_DIGITS-1:0] en;
    logic [SEG_W-1:0]      val;
  } sample_t;

  function automatic slot_kind_e slot_kind(input logic [NUM_DIGITS-1:0] en);
    int unsigned lows;
    lows = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!en[i]) lows++;
    end
    if (lows == 0)      return SLOT_IDLE;
    else if (lows == 1) return SLOT_SINGLE;
    else                return SLOT_MULTI;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Seven-segment glyph to hex nibble decoder.
// Latency: combinational.
// Backpressure: none.
// Ports: pattern (segment bus in), nibble (decoded value, 0 when not legal),
//        legal (pattern is one of the 16 hex glyphs), blank (all segments off).
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       nibble,
  output logic             legal,
  output logic             blank
);

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b0;
    blank  = (pattern == SEG_BLANK);
    for (int k = 0; k < 16; k++) begin
      if (pattern == SEG_HEX[k]) begin
        nibble = 4'(k);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers six hex digits from a multiplexed, active-low-scanned 7-segment display.
// Latency: inputs registered once; a slot is accepted STABLE_CYCLES edges after it is first sampled.
// Backpressure: none; the scan is free-running and every accepted slot is absorbed.
// Ports: clk/rst (sync active-high); led_value/led_enable scan inputs; digits, digit_valid,
//        blank state outputs; frame_done, err_multi, err_pattern one-cycle pulses.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEG_W-1:0]        led_value,
  input  logic [NUM_DIGITS-1:0]   led_enable,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    frame_done,
  output logic                    err_multi,
  output logic                    err_pattern
);

  // The counter reads STABLE_CYCLES-1 on the last edge of a full window, so the
  // accept lands on the following edge and the counter moves past it (or saturates
  // above it), giving exactly one accept per window.
  localparam logic [CNT_W-1:0] ACCEPT_CNT = CNT_W'(STABLE_CYCLES - 1);
  localparam sample_t          SAMPLE_RST = '{en: '1, val: '0};

  sample_t                  sample_q, sample_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0]  digits_q, digits_d;
  logic [NUM_DIGITS-1:0]    valid_q, valid_d;
  logic [NUM_DIGITS-1:0]    blank_q, blank_d;
  logic [NUM_DIGITS-1:0]    mask_q, mask_d;
  logic                     frame_done_q, frame_done_d;
  logic                     err_multi_q, err_multi_d;
  logic                     err_pattern_q, err_pattern_d;

  logic [2:0]               slot_idx;
  logic [3:0]               dec_nibble;
  logic                     dec_legal;
  logic                     dec_blank;

  seg_pattern_decode u_decode (
    .pattern (sample_q.val),
    .nibble  (dec_nibble),
    .legal   (dec_legal),
    .blank   (dec_blank)
  );

  always_comb begin
    sample_d      = {led_enable, led_value};
    cnt_d         = cnt_q;
    digits_d      = digits_q;
    valid_d       = valid_q;
    blank_d       = blank_q;
    mask_d        = mask_q;
    frame_done_d  = 1'b0;
    err_multi_d   = 1'b0;
    err_pattern_d = 1'b0;

    // Only meaningful when exactly one select is low.
    slot_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!sample_q.en[i]) slot_idx = 3'(i);
    end

    if (sample_d != sample_q)  cnt_d = '0;
    else if (cnt_q != '1)      cnt_d = cnt_q + CNT_W'(1);

    if (cnt_q == ACCEPT_CNT) begin
      unique case (slot_kind(sample_q.en))
        SLOT_MULTI: err_multi_d = 1'b1;
        SLOT_SINGLE: begin
          if (dec_legal || dec_blank) begin
            // A blank glyph decodes to nibble 0, which is the value stored for it.
            digits_d[4*slot_idx +: 4] = dec_nibble;
            valid_d[slot_idx]         = 1'b1;
            blank_d[slot_idx]         = dec_blank;
            mask_d[slot_idx]          = 1'b1;
          end else begin
            err_pattern_d     = 1'b1;
            valid_d[slot_idx] = 1'b0;
            blank_d[slot_idx] = 1'b0;
          end
          // Only a legal/blank accept can complete the mask, so this never
          // coincides with err_pattern.
          if (mask_d == '1) begin
            frame_done_d = 1'b1;
            mask_d       = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q      <= SAMPLE_RST;
      cnt_q         <= '0;
      digits_q      <= '0;
      valid_q       <= '0;
      blank_q       <= '0;
      mask_q        <= '0;
      frame_done_q  <= 1'b0;
      err_multi_q   <= 1'b0;
      err_pattern_q <= 1'b0;
    end else begin
      sample_q      <= sample_d;
      cnt_q         <= cnt_d;
      digits_q      <= digits_d;
      valid_q       <= valid_d;
      blank_q       <= blank_d;
      mask_q        <= mask_d;
      frame_done_q  <= frame_done_d;
      err_multi_q   <= err_multi_d;
      err_pattern_q <= err_pattern_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign blank       = blank_q;
  assign frame_done  = frame_done_q;
  assign err_multi   = err_multi_q;
  assign err_pattern = err_pattern_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: the driver predicts each observable
// accept or reset effect and queues it; the monitor pops on every output change.
module tb_seg_scan_decoder;

  localparam int S = 4;
  localparam logic [12:0] SENT = {6'h3f, 7'h00};  // sample value after reset

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  led_value;
  logic [5:0]  led_enable;
  logic [23:0] digits;
  logic [5:0]  digit_valid, blank;
  logic        frame_done, err_multi, err_pattern;

  seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .led_value   (led_value),
    .led_enable  (led_enable),
    .digits      (digits),
    .digit_valid (digit_valid),
    .blank       (blank),
    .frame_done  (frame_done),
    .err_multi   (err_multi),
    .err_pattern (err_pattern)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Glyph table written out independently of the design package.
  logic [6:0] pat_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  typedef struct {
    int          cyc;
    logic [23:0] dig;
    logic [5:0]  vld;
    logic [5:0]  blk;
    logic [2:0]  pul;   // {frame_done, err_multi, err_pattern}
  } ev_t;

  ev_t exp_q [$];

  // Reference model state.
  logic [3:0] m_dig [6];
  logic [5:0] m_vld = '0, m_blk = '0, m_mask = '0;
  logic [12:0] prev_sample = SENT;

  function automatic logic [23:0] m_digits();
    logic [23:0] v;
    for (int i = 0; i < 6; i++) v[4*i +: 4] = m_dig[i];
    return v;
  endfunction

  task automatic model_accept(input logic [5:0] en, input logic [6:0] val, input int at);
    int lows, idx, found;
    logic [23:0] od;
    logic [5:0] ov, ob;
    ev_t e;
    lows = 0; idx = 0; found = -1;
    od = m_digits(); ov = m_vld; ob = m_blk;
    e.cyc = at; e.pul = 3'b000;
    for (int i = 0; i < 6; i++) if (!en[i]) begin lows++; idx = i; end
    if (lows == 0) return;
    if (lows >= 2) e.pul = 3'b010;
    else begin
      for (int k = 0; k < 16; k++) if (pat_tab[k] == val) found = k;
      if (found >= 0 || val == 7'h00) begin
        m_dig[idx]  = (found >= 0) ? 4'(found) : 4'h0;
        m_vld[idx]  = 1'b1;
        m_blk[idx]  = (found < 0);
        m_mask[idx] = 1'b1;
        if (m_mask == 6'h3f) begin e.pul = 3'b100; m_mask = '0; end
      end else begin
        e.pul = 3'b001;
        m_vld[idx] = 1'b0;
        m_blk[idx] = 1'b0;
      end
    end
    e.dig = m_digits(); e.vld = m_vld; e.blk = m_blk;
    if (e.pul != 0 || e.dig != od || e.vld != ov || e.blk != ob) exp_q.push_back(e);
  endtask

  // Called at a negedge: the sample becomes visible at edge cyc+1 and is held len edges.
  task automatic seg(input logic [5:0] en, input logic [6:0] val, input int len);
    int e0;
    led_enable = en; led_value = val;
    e0 = cyc + 1;
    if (len >= S) model_accept(en, val, e0 + S);
    prev_sample = {en, val};
    repeat (len) @(negedge clk);
  endtask

  task automatic do_reset();
    ev_t e;
    e.cyc = cyc + 1; e.dig = '0; e.vld = '0; e.blk = '0; e.pul = '0;
    if (m_digits() != 0 || m_vld != 0 || m_blk != 0) exp_q.push_back(e);
    for (int i = 0; i < 6; i++) m_dig[i] = 4'h0;
    m_vld = '0; m_blk = '0; m_mask = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_digits", digits, 0);
    chk("rst_valid", digit_valid, 0);
    chk("rst_blank", blank, 0);
    chk("rst_pulses", {frame_done, err_multi, err_pattern}, 0);
    rst = 1'b0;
    prev_sample = SENT;
  endtask

  task automatic rand_sample(output logic [5:0] en, output logic [6:0] val);
    int r;
    do begin
      r = $urandom_range(0, 9);
      if (r < 6)      en = ~(6'b000001 << $urandom_range(0, 5));
      else if (r < 8) en = 6'h3f;
      else            en = 6'($urandom);
      r = $urandom_range(0, 9);
      if (r < 6)      val = pat_tab[$urandom_range(0, 15)];
      else if (r < 7) val = 7'h00;
      else            val = 7'($urandom);
    end while ({en, val} == prev_sample || {en, val} == SENT);
  endtask

  // Monitor: any pulse or state change is one DUT event to be matched in order.
  bit          mon_en = 0;
  logic [23:0] p_dig = '0;
  logic [5:0]  p_vld = '0, p_blk = '0;
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (frame_done || err_multi || err_pattern ||
          digits !== p_dig || digit_valid !== p_vld || blank !== p_blk) begin
        if (exp_q.size() == 0) begin
          chk("expected_event_available", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("ev_cycle", cyc, e.cyc);
          chk("ev_digits", digits, e.dig);
          chk("ev_valid", digit_valid, e.vld);
          chk("ev_blank", blank, e.blk);
          chk("ev_pulses", {frame_done, err_multi, err_pattern}, e.pul);
        end
      end
      p_dig = digits; p_vld = digit_valid; p_blk = blank;
    end
  end

  logic [5:0] r_en;
  logic [6:0] r_val;

  initial begin
    for (int i = 0; i < 6; i++) m_dig[i] = 4'h0;
    rst = 1'b1; led_enable = 6'h3f; led_value = 7'h00;
    repeat (2) @(negedge clk);
    chk("reset_digits", digits, 0);
    chk("reset_valid", digit_valid, 0);
    chk("reset_blank", blank, 0);
    chk("reset_pulses", {frame_done, err_multi, err_pattern}, 0);
    rst = 1'b0;
    mon_en = 1;

    // Single digit 0 on digit 0, minimum window.
    seg(6'b111110, 7'h7E, 4);
    // Full scan 1..6, frame completes on digit 5.
    seg(6'b111110, 7'h30, 6);
    seg(6'b111101, 7'h6D, 6);
    seg(6'b111011, 7'h79, 6);
    seg(6'b110111, 7'h33, 6);
    seg(6'b101111, 7'h5B, 6);
    seg(6'b011111, 7'h5F, 6);
    // Two selects low.
    seg(6'b111100, 7'h7F, 4);
    // Illegal glyph then blank on digit 4.
    seg(6'b101111, 7'h01, 4);
    seg(6'b101111, 7'h00, 4);
    // Windows one short of acceptance.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) seg(6'b111110, 7'h7E, 3);
      else            seg(6'b111101, 7'h6D, 3);
    end
    // Reset part-way into a window, then the same sample needs a fresh full window.
    seg(6'b111011, 7'h79, 2);
    do_reset();
    seg(6'b111011, 7'h79, 4);
    seg(6'b111011, 7'h30, 3);
    seg(6'b111011, 7'h6D, 5);

    // Randomized scan with occasional resets.
    for (int n = 0; n < 250; n++) begin
      rand_sample(r_en, r_val);
      if ($urandom_range(0, 49) == 0) begin
        seg(r_en, r_val, $urandom_range(1, S - 1));
        do_reset();
      end else begin
        seg(r_en, r_val, $urandom_range(1, 8));
      end
    end

    seg(6'h3f, 7'h01, 12);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..255: consecutive identical samples required before a scan slot is accepted.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 led_value  input  7  segment bus {A,B,C,D,E,F,G}, bit6=A, active-high (1 = segment lit).
REQ-005 led_enable  input  6  digit selects, active-low, bit i = digit i.
REQ-006 digits  output  24  decoded hex nibbles, digit i at bits [4i+3:4i].
REQ-007 digit_valid  output  6  bit i set once digit i has been accepted with a legal pattern.
REQ-008 blank  output  6  bit i set when digit i was last accepted with all segments off.
REQ-009 frame_done  output  1  one-cycle pulse when all six digits have been accepted since the previous pulse or reset.
REQ-010 err_multi  output  1  one-cycle pulse: accepted slot had more than one enable low.
REQ-011 err_pattern  output  1  one-cycle pulse: accepted slot had a single enable low and an illegal segment pattern.

Function
REQ-012 Inputs SHALL be registered once; the pair {led_enable, led_value} is the sample.
REQ-013 An 8-bit stability counter SHALL clear whenever the sample differs from the previous sample and increment, saturating, otherwise.
REQ-014 Acceptance SHALL occur exactly once per stable window: sample held for STABLE_CYCLES consecutive edges starting at edge E0 -> outputs update at edge E0+STABLE_CYCLES; no further accept until the sample changes.
REQ-015 Accept with led_enable = 6'b111111 SHALL have no effect (idle slot).
REQ-016 Accept with two or more enable bits low SHALL pulse err_multi and leave digits, digit_valid, blank, and frame mask unchanged.
REQ-017 Legal patterns (hex of led_value) SHALL decode: 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9, 77=A, 1F=b, 4E=C, 3D=d, 4F=E, 47=F.
REQ-018 Legal accept on digit i SHALL write the nibble, set digit_valid[i], clear blank[i], and set frame mask bit i.
REQ-019 Pattern 00 on digit i SHALL write nibble 0, set digit_valid[i] and blank[i], and set frame mask bit i.
REQ-020 Any other pattern on digit i SHALL pulse err_pattern, clear digit_valid[i] and blank[i], keep the nibble, and not set the mask bit.
REQ-021 When an accept completes the mask to 6'b111111, frame_done SHALL pulse in that same output cycle and the mask SHALL clear to 0.
REQ-022 Re-accepting an already-masked digit SHALL update its outputs without pulsing frame_done.
REQ-023 err_multi, err_pattern, and frame_done SHALL be mutually exclusive within a cycle.

Reset
REQ-024 With rst high at a rising edge: digits=0, digit_valid=0, blank=0, frame_done=0, err_multi=0, err_pattern=0, mask=0, counter=0, sample register={6'b111111, 7'b0}.
REQ-025 Reset mid-window SHALL discard the partial window; the first accept after reset requires a full STABLE_CYCLES window.

Structure
REQ-026 The segment-pattern constants of REQ-017, digit count (6), and segment width (7) SHALL reside in the shared seg_pkg package, reusable by display drivers.
REQ-027 Pattern-to-nibble decode SHALL be a sub-module seg_pattern_decode (inputs: 7-bit pattern; outputs: nibble, legal, blank).

Verification
REQ-028 enable=111110, value=7E, held 4 cycles -> at E0+4, digits[3:0]=0, digit_valid=000001, no pulses.
REQ-029 Scan digits 0..5 with 30,6D,79,33,5B,5F, each held 6 cycles -> digits=24'h654321, digit_valid=111111, frame_done exactly once after digit 5.
REQ-030 enable=111100, value=7F, held 4 cycles -> err_multi one pulse; all other outputs unchanged.
REQ-031 enable=101111, value=01 -> err_pattern one pulse, digit_valid[4]=0. Then value=00 -> blank[4]=1, digit_valid[4]=1.
REQ-032 Sample toggled every 3 cycles with STABLE_CYCLES=4 -> no accepts. Then rst asserted on cycle 3 of a stable window -> all outputs are at reset values, and the next accept needs 4 fresh cycles.
